// File: rtl/seg7_pkg.sv
// Shared constants, position index type and the active-low hex font for the
// common-anode 7-segment scan driver.
package seg7_pkg;

    localparam int NUM_POS = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef logic [2:0] posIdx_t;

    // Segment order {g,f,e,d,c,b,a}, 0 lights the segment; 'b' and 'd' are lowercase glyphs.
    function automatic logic [6:0] hexFont(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit-nibble bus from the display manager (master) to the scan driver (slave).
interface seg7_scan_driver_if;

    logic [3:0] seg0;
    logic [3:0] seg1;
    logic [3:0] seg2;
    logic [3:0] seg3;
    logic [3:0] seg5;
    logic       dash;
    logic [5:0] pos_en;

    modport master (output seg0, seg1, seg2, seg3, seg5, dash, pos_en);
    modport slave  (input  seg0, seg1, seg2, seg3, seg5, dash, pos_en);

endinterface

// File: rtl/seg7_font.sv
// Combinational nibble to active-low cathode decoder.
module seg7_font
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segN
);

    assign segN = hexFont(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Six-position common-anode scan driver with per-frame input snapshot and anti-ghost guard.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros of the four value digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int GUARD_CYCLES = 500
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    seg7_scan_driver_if.slave        digits,
    output logic [5:0]               an_n,
    output logic [6:0]               seg_n,
    output logic                     dp_n,
    output logic                     frame_start
);

    localparam int               CNT_W      = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(DIGIT_CYCLES - GUARD_CYCLES);
    localparam posIdx_t          LAST_POS   = posIdx_t'(NUM_POS - 1);

    logic [CNT_W-1:0] slotCnt;
    posIdx_t          pos;
    logic [3:0][3:0]  snapVal, curVal;
    logic [3:0]       snapMode, curMode;
    logic             snapDash, curDash;
    logic [5:0]       snapEn, curEn;
    logic [3:0]       lzBlank;
    logic [3:0]       fontNibble;
    logic [6:0]       fontSeg, posSeg;
    logic             takeSnap, slotActive;

    assign takeSnap   = (slotCnt == '0) && (pos == '0);
    assign slotActive = slotCnt < ACTIVE_END;
    assign dp_n       = 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotCnt <= '0;
            pos     <= '0;
        end else if (slotCnt == CNT_MAX) begin
            slotCnt <= '0;
            pos     <= (pos == LAST_POS) ? posIdx_t'(0) : pos + 3'd1;
        end else begin
            slotCnt <= slotCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapVal  <= '0;
            snapMode <= '0;
            snapDash <= 1'b0;
            snapEn   <= '0;
        end else if (takeSnap) begin
            snapVal  <= {digits.seg3, digits.seg2, digits.seg1, digits.seg0};
            snapMode <= digits.seg5;
            snapDash <= digits.dash;
            snapEn   <= digits.pos_en;
        end
    end

    // The snapshot registers are still loading during the first slot cycle, so the live
    // inputs stand in for them there; the whole frame still comes from one sample.
    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        curVal  = snapVal;
        curMode = snapMode;
        curDash = snapDash;
        curEn   = snapEn;
        if (takeSnap) begin
            curVal  = {digits.seg3, digits.seg2, digits.seg1, digits.seg0};
            curMode = digits.seg5;
            curDash = digits.dash;
            curEn   = digits.pos_en;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign lzBlank[3] = (curVal[3] == 4'h0);
    assign lzBlank[2] = lzBlank[3] && (curVal[2] == 4'h0);
    assign lzBlank[1] = lzBlank[2] && (curVal[1] == 4'h0);
    assign lzBlank[0] = 1'b0;
`else
    assign lzBlank = '0;
`endif

    always_comb begin
        fontNibble = curMode;
        if (pos < 3'd4) fontNibble = curVal[pos[1:0]];
    end

    seg7_font u_font (
        .nibble (fontNibble),
        .segN   (fontSeg)
    );

    // A disabled position keeps its anode slot so the duty cycle of the others is unchanged.
    always_comb begin
        posSeg = fontSeg;
        if (pos == 3'd4) posSeg = curDash ? SEG_DASH : SEG_BLANK;
        if (!curEn[pos] || ((pos < 3'd4) && lzBlank[pos[1:0]])) posSeg = SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n        <= '1;
            seg_n       <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            frame_start <= takeSnap;
            if (slotActive) begin
                an_n  <= ~(6'b000001 << pos);
                seg_n <= posSeg;
            end else begin
                an_n  <= '1;
                seg_n <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: directed stimulus pushes expected slot glyphs,
// a negedge monitor pops and compares them and checks slot/guard/frame timing.
module tb_seg7_scan_driver;

    localparam int DC     = 20;
    localparam int GC     = 4;
    localparam int ACTIVE = DC - GC;
    localparam int FRAME  = 6 * DC;
    localparam int NONE   = 7;

    localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        int         pos;
        logic [6:0] seg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic       frame_start;

    int   checks = 0;
    int   errors = 0;
    exp_t sbQ[$];

    int         prevIdx = NONE;
    int         runLen = 0;
    int         guardLen = 0;
    bit         guardValid = 1'b0;
    int         lastFs = -1;
    int         cyc = 0;
    bit         monOn = 1'b0;
    logic [6:0] slotSeg = 7'h7F;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .DIGIT_CYCLES (DC),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (bus),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference for what each position should show from the current inputs.
    function automatic logic [6:0] modelSeg(input int p);
        logic [3:0] v [4];
        bit         lead;
        v[0] = bus.seg0;
        v[1] = bus.seg1;
        v[2] = bus.seg2;
        v[3] = bus.seg3;
        lead = 1'b0;
        if (!bus.pos_en[p]) return 7'h7F;
        if (p == 4) return bus.dash ? 7'h3F : 7'h7F;
        if (p == 5) return FONT[bus.seg5];
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int k = 3; k >= p; k--) lead = lead && (v[k] == 4'h0);
`endif
        if (p >= 1 && lead) return 7'h7F;
        return FONT[v[p]];
    endfunction

    task automatic pushFrame();
        for (int p = 0; p < 6; p++) sbQ.push_back('{p, modelSeg(p)});
    endtask

    task automatic waitFrame();
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!frame_start && n < 2 * FRAME);
        check("frame_timeout", 32'(frame_start), 32'd1);
    endtask

    task automatic setValue(input logic [15:0] value);
        bus.seg3 = value[15:12];
        bus.seg2 = value[11:8];
        bus.seg1 = value[7:4];
        bus.seg0 = value[3:0];
    endtask

    always @(negedge clk) begin
        int   idx;
        int   zeros;
        bit   newSlot;
        exp_t e;
        cyc++;
        if (monOn) begin
            if (!rst_n) begin
                check("rst_an", 32'(an_n), 32'h3F);
                check("rst_seg", 32'(seg_n), 32'h7F);
                check("rst_fs", 32'(frame_start), 32'd0);
                prevIdx    = NONE;
                guardValid = 1'b0;
                guardLen   = 0;
                lastFs     = -1;
            end else begin
                zeros = 0;
                idx   = NONE;
                for (int i = 0; i < 6; i++) begin
                    if (!an_n[i]) begin
                        zeros++;
                        idx = i;
                    end
                end
                check("anode_onehot", 32'(zeros <= 1), 32'd1);
                newSlot = (idx != NONE) && (idx != prevIdx);
                if (newSlot) begin
                    if (prevIdx != NONE) begin
                        guardLen   = 0;
                        guardValid = 1'b1;
                    end
                    if (guardValid) check("guard_len", 32'(guardLen), 32'(GC));
                    if (sbQ.size() == 0) begin
                        check("sb_empty", 32'(sbQ.size()), 32'd1);
                    end else begin
                        e = sbQ.pop_front();
                        check("slot_pos", 32'(idx), 32'(e.pos));
                        check("slot_seg", 32'(seg_n), 32'(e.seg));
                    end
                    slotSeg = seg_n;
                    runLen  = 1;
                end else if (idx != NONE) begin
                    runLen++;
                    check("seg_stable", 32'(seg_n), 32'(slotSeg));
                end else begin
                    check("guard_seg", 32'(seg_n), 32'h7F);
                    if (prevIdx != NONE) begin
                        check("active_len", 32'(runLen), 32'(ACTIVE));
                        guardLen   = 1;
                        guardValid = 1'b1;
                    end else begin
                        guardLen++;
                    end
                end
                check("frame_start", 32'(frame_start), 32'(newSlot && idx == 0));
                if (frame_start) begin
                    if (lastFs >= 0) check("frame_period", 32'(cyc - lastFs), 32'(FRAME));
                    lastFs = cyc;
                end
                check("dp_n", 32'(dp_n), 32'd1);
                prevIdx = idx;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        setValue(16'h1234);
        bus.seg5   = 4'hB;
        bus.dash   = 1'b1;
        bus.pos_en = 6'h3F;
        monOn      = 1'b1;

        // Reset held: everything blank.
        repeat (4) @(posedge clk);
        #2;
        check("reset_an", 32'(an_n), 32'h3F);
        check("reset_seg", 32'(seg_n), 32'h7F);
        check("reset_fs", 32'(frame_start), 32'd0);

        // Frames 1 and 2 from the initial inputs.
        pushFrame();
        pushFrame();
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("fs_after_release", 32'(frame_start), 32'd1);
        check("first_anode", 32'(an_n), 32'h3E);
        @(posedge clk);
        #2;
        check("fs_one_cycle", 32'(frame_start), 32'd0);

        // Mid-frame change at position 2: visible only from frame 3.
        waitFrame();
        repeat (2 * DC) @(posedge clk);
        #2;
        bus.seg0 = 4'h7;
        pushFrame();

        // Frame 4: dash off and position 5 disabled, anodes still cycle.
        waitFrame();
        bus.dash   = 1'b0;
        bus.pos_en = 6'b011111;
        pushFrame();

        // Frames 5 and 6: leading-zero patterns.
        waitFrame();
        setValue(16'h0050);
        bus.dash   = 1'b1;
        bus.pos_en = 6'h3F;
        bus.seg5   = 4'h2;
        pushFrame();
        waitFrame();
        setValue(16'h0000);
        pushFrame();

        // Frame 7: hex glyphs above 9.
        waitFrame();
        setValue(16'hCDEF);
        bus.seg5 = 4'h9;
        pushFrame();

        // Reset at position 3, slot cycle 7 of frame 7.
        waitFrame();
        repeat (3 * DC + 6) @(posedge clk);
        #2;
        check("pre_reset_pos3", 32'(an_n), 32'h37);
        setValue(16'h8609);
        bus.seg5   = 4'hA;
        bus.pos_en = 6'b101111;
        rst_n = 1'b0;
        #1;
        check("midreset_an", 32'(an_n), 32'h3F);
        check("midreset_seg", 32'(seg_n), 32'h7F);
        sbQ.delete();
        pushFrame();
        pushFrame();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("fs_after_midreset", 32'(frame_start), 32'd1);
        check("restart_pos0", 32'(an_n), 32'h3E);

        waitFrame();
        repeat (5 * DC + 2) @(posedge clk);
        #2;
        check("sb_drained", 32'(sbQ.size()), 32'd0);
        monOn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
